// File: rtl/cpu6_memstage_lsu.sv
// rtl/cpu6_memstage_lsu.sv - MEM-stage load/store unit with req/gnt/rvalid data bus and MEM/WB register
module cpu6_memstage_lsu #(
  parameter int XLEN    = 32,
  parameter int RFIDX   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_memwriteM,
  input  logic             i_memtoregM,
  input  logic [XLEN-1:0]  i_aluoutM,
  input  logic [XLEN-1:0]  i_writedataM,
  input  logic [RFIDX-1:0] i_writeregM,
  input  logic             i_regwriteM,
  input  logic [XLEN-1:0]  i_pcplus4M,
  input  logic             i_jumpM,
  output logic             o_stallM,
  output logic             o_dbus_req,
  output logic             o_dbus_we,
  output logic [XLEN-1:0]  o_dbus_addr,
  output logic [XLEN-1:0]  o_dbus_wdata,
  input  logic             i_dbus_gnt,
  input  logic             i_dbus_rvalid,
  input  logic [XLEN-1:0]  i_dbus_rdata,
  output logic [XLEN-1:0]  o_readdataW,
  output logic [XLEN-1:0]  o_aluoutW,
  output logic [RFIDX-1:0] o_writeregW,
  output logic             o_regwriteW,
  output logic             o_memtoregW,
  output logic [XLEN-1:0]  o_pcplus4W,
  output logic             o_jumpW,
  output logic             o_buserrW
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Last counter value before the timeout is declared; the WAIT cycle seeing it is the TIMEOUT-th.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  logic [7:0]       r_wait_cnt;

  logic [XLEN-1:0]  r_readdataW;
  logic [XLEN-1:0]  r_aluoutW;
  logic [RFIDX-1:0] r_writeregW;
  logic             r_regwriteW;
  logic             r_memtoregW;
  logic [XLEN-1:0]  r_pcplus4W;
  logic             r_jumpW;
  logic             r_buserrW;

  logic             w_memop;
  logic             w_load;
  logic             w_in_wait;
  logic             w_timeout;
  logic             w_done;
  logic             w_stall;
  logic             w_req;
  logic             w_load_done;

  assign w_memop     = i_memwriteM | i_memtoregM;
  // When both flags are set the store takes priority, so it is not treated as a load.
  assign w_load      = i_memtoregM & ~i_memwriteM;
  assign w_in_wait   = (r_state == S_WAIT);
  // A response arriving in the final WAIT cycle beats the timeout.
  assign w_timeout   = w_in_wait & ~i_dbus_rvalid & (r_wait_cnt == TO_LAST);
  assign w_done      = w_in_wait & (i_dbus_rvalid | w_timeout);
  assign w_load_done = w_in_wait & i_dbus_rvalid & w_load;

  // Stall and request are suppressed while reset is held so the bus goes quiet right after the reset edge.
  assign w_stall = w_memop & ~w_done & ~i_reset;

  // Request is raised from IDLE as soon as a memop is present, and held in REQ until granted.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_IDLE:  w_req = w_memop;
      S_REQ:   w_req = 1'b1;
      S_WAIT:  w_req = 1'b0;
      default: w_req = 1'b0;
    endcase
    if (i_reset) begin
      w_req = 1'b0;
    end
  end

  assign o_stallM     = w_stall;
  assign o_dbus_req   = w_req;
  assign o_dbus_we    = i_memwriteM;
  assign o_dbus_addr  = {i_aluoutM[XLEN-1:2], 2'b00};
  assign o_dbus_wdata = i_writedataM;

  // Bus handshake FSM with the WAIT-cycle counter used for the timeout.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            if (i_dbus_gnt) begin
              r_state    <= S_WAIT;
              r_wait_cnt <= 8'd0;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_dbus_gnt) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        S_WAIT: begin
          if (w_done) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // MEM/WB pipeline register: advance when not stalled, otherwise insert a bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_readdataW <= '0;
      r_aluoutW   <= '0;
      r_writeregW <= '0;
      r_regwriteW <= 1'b0;
      r_memtoregW <= 1'b0;
      r_pcplus4W  <= '0;
      r_jumpW     <= 1'b0;
      r_buserrW   <= 1'b0;
    end else if (w_stall) begin
      r_regwriteW <= 1'b0;
      r_memtoregW <= 1'b0;
      r_jumpW     <= 1'b0;
      r_buserrW   <= 1'b0;
    end else begin
      if (w_load_done) begin
        r_readdataW <= i_dbus_rdata;
      end
      r_aluoutW   <= i_aluoutM;
      r_writeregW <= i_writeregM;
      r_regwriteW <= i_regwriteM & ~w_timeout;
      r_memtoregW <= i_memtoregM & ~w_timeout;
      r_pcplus4W  <= i_pcplus4M;
      r_jumpW     <= i_jumpM;
      r_buserrW   <= w_timeout;
    end
  end

  assign o_readdataW = r_readdataW;
  assign o_aluoutW   = r_aluoutW;
  assign o_writeregW = r_writeregW;
  assign o_regwriteW = r_regwriteW;
  assign o_memtoregW = r_memtoregW;
  assign o_pcplus4W  = r_pcplus4W;
  assign o_jumpW     = r_jumpW;
  assign o_buserrW   = r_buserrW;

endmodule
